// File: rtl/rv_defs.sv
// rv_defs: shared encodings for the iterative M-extension multiplier
//  MUL_OP_*   : request opcodes (MUL, MULH, MULHSU, MULHU)
//  mul_state_e: multiplier FSM state codes
//  mul_class  : operand signedness class of an opcode
package rv_defs;
   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;
   typedef enum logic [1:0] {MUL_IDLE = 2'd0, MUL_CALC = 2'd1, MUL_DONE = 2'd2} mul_state_e;
   // 0: both operands signed, 1: signed x unsigned, 2: both unsigned
   function automatic logic [1:0] mul_class(input logic [1:0] op);
      return op == MUL_OP_MULHU ? 2'd2 : op == MUL_OP_MULHSU ? 2'd1 : 2'd0;
   endfunction
endpackage

// File: rtl/rv_booth_digit.sv
// rv_booth_digit: radix-4 Booth recoding of one 3-bit multiplier window
//  win  in  3  {b[2k+1], b[2k], b[2k-1]}
//  zero out 1  digit is 0
//  one  out 1  digit magnitude is 1
//  two  out 1  digit magnitude is 2
//  neg  out 1  digit is negative
module rv_booth_digit (
   input  logic [2:0] win,
   output logic       zero,
   output logic       one,
   output logic       two,
   output logic       neg
);
   assign one  = win[1] ^ win[0];
   assign two  = (win[2] & ~win[1] & ~win[0]) | (~win[2] & win[1] & win[0]);
   assign zero = ~one & ~two;
   assign neg  = win[2] & ~(win[1] & win[0]);
endmodule

// File: rtl/rv_mul_iter.sv
// rv_mul_iter: iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU
//  clk, rstn                         clock, asynchronous active-low reset
//  req_valid_i/req_ready_o           request handshake
//  req_op_i, req_a_i, req_b_i        opcode, multiplicand (rs1), multiplier (rs2)
//  flush_i                           kill in-flight op and drop the reuse tag
//  resp_valid_o/resp_ready_i         response handshake
//  resp_data_o                       result
//  Optional macro RV_MUL_REUSE_EN: remember the last full product and answer a
//  matching request after a single cycle.
module rv_mul_iter
   import rv_defs::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [1:0]      req_op_i,
   input  logic [XLEN-1:0] req_a_i,
   input  logic [XLEN-1:0] req_b_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] resp_data_o
);
   localparam int NDIG = XLEN / 2 + 1;
   localparam int CW   = $clog2(NDIG);
   // Bits above 2*XLEN never reach the result, so the accumulator stops there.
   localparam int PW   = 2 * XLEN;
   mul_state_e      state, state_nx;
   logic [1:0]      op;
   logic [PW-1:0]   acc, a_sh, term, addend, acc_nx, res_src;
   logic [XLEN+1:0] b_sh;
   logic            b_prev;
   logic [CW-1:0]   cnt;
   logic            d_zero, d_one, d_two, d_neg, sub;
   logic            resp_hs, accept, last, fast, a_sgn, b_sgn;
   assign a_sgn        = req_op_i != MUL_OP_MULHU;
   assign b_sgn        = req_op_i == MUL_OP_MUL || req_op_i == MUL_OP_MULH;
   assign resp_valid_o = state == MUL_DONE;
   assign resp_hs      = resp_valid_o & resp_ready_i;
   assign req_ready_o  = !flush_i & (state == MUL_IDLE | resp_hs);
   assign accept       = req_valid_i & req_ready_o;
   assign last         = fast | (cnt == CW'(NDIG - 1));
   rv_booth_digit u_digit (
      .win  ({b_sh[1:0], b_prev}),
      .zero (d_zero),
      .one  (d_one),
      .two  (d_two),
      .neg  (d_neg)
   );
   // a_sh already carries the 4^k weight of the current digit
   assign term   = ({PW{d_one}} & a_sh) | ({PW{d_two}} & {a_sh[PW-2:0], 1'b0});
   assign sub    = d_neg & ~d_zero;
   assign addend = sub ? ~term : term;
   assign acc_nx = acc + addend + PW'(sub);
`ifdef RV_MUL_REUSE_EN
   logic            tag_v, hit, hit_q;
   logic [XLEN-1:0] tag_a, tag_b;
   logic [1:0]      tag_cls;
   logic [PW-1:0]   prod;
   // The low half is identical for every signedness, so MUL hits any class.
   assign hit     = tag_v & tag_a == req_a_i & tag_b == req_b_i &
                    (req_op_i == MUL_OP_MUL | mul_class(req_op_i) == tag_cls);
   assign fast    = hit_q;
   assign res_src = hit_q ? prod : acc_nx;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         tag_v   <= 1'b0;
         hit_q   <= 1'b0;
         tag_a   <= '0;
         tag_b   <= '0;
         tag_cls <= '0;
         prod    <= '0;
      end else if (flush_i) begin
         tag_v <= 1'b0;
         hit_q <= 1'b0;
      end else if (accept) begin
         hit_q <= hit;
         if (!hit) begin
            tag_v   <= 1'b0;
            tag_a   <= req_a_i;
            tag_b   <= req_b_i;
            tag_cls <= mul_class(req_op_i);
         end
      end else if (state == MUL_CALC && last && !hit_q) begin
         tag_v <= 1'b1;
         prod  <= acc_nx;
      end
`else
   assign fast    = 1'b0;
   assign res_src = acc_nx;
`endif
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= MUL_IDLE;
      else state <= state_nx;
   always_comb
      state_nx = flush_i ? MUL_IDLE :
                 accept ? MUL_CALC :
                 (state == MUL_CALC && last) ? MUL_DONE :
                 resp_hs ? MUL_IDLE : state;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         op          <= MUL_OP_MUL;
         acc         <= '0;
         a_sh        <= '0;
         b_sh        <= '0;
         b_prev      <= 1'b0;
         cnt         <= '0;
         resp_data_o <= '0;
      end else if (flush_i) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         op     <= req_op_i;
         acc    <= '0;
         cnt    <= '0;
         a_sh   <= {{XLEN{a_sgn & req_a_i[XLEN-1]}}, req_a_i};
         b_sh   <= {{2{b_sgn & req_b_i[XLEN-1]}}, req_b_i};
         b_prev <= 1'b0;
      end else if (state == MUL_CALC) begin
         acc    <= acc_nx;
         a_sh   <= {a_sh[PW-3:0], 2'b00};
         b_sh   <= {2'b00, b_sh[XLEN+1:2]};
         b_prev <= b_sh[1];
         cnt    <= last ? cnt : cnt + CW'(1);
         if (last) resp_data_o <= op == MUL_OP_MUL ? res_src[XLEN-1:0] : res_src[PW-1:XLEN];
      end
endmodule
